seg_digit_scanner: RTL and testbench

//  Time-multiplexes four hex nibbles onto the 4-digit 7-seg display. Sits between clock_div and
//  the 7-seg decoder.

---
 rtl/seg_digit_scanner_pkg.sv | 38 +++
 rtl/seg_digit_scanner_edge_sync.sv | 34 +++
 rtl/seg_digit_scanner.sv | 111 +++++++++++
 tb/tb_seg_digit_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_digit_scanner_pkg.sv
// Shared definitions for the 4-digit 7-segment scanner: state encoding, display
// constants and the pure helper functions for nibble selection and blanking.
package seg_digit_scanner_pkg;

   localparam int N_DIGITS = 4;
   localparam logic [N_DIGITS-1:0] ANODE_OFF = 4'b1111;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_DEAD,
      ST_DRIVE
   } scan_state_t;

   function automatic logic [3:0] nibble_of(input logic [4*N_DIGITS-1:0] v,
                                            input logic [1:0]            idx);
      return v[{idx, 2'b00} +: 4];
   endfunction

   // Leading-zero blanking: digit idx (idx > 0) goes dark when it and every
   // more significant nibble are zero, so digit 0 always shows something.
   function automatic logic digit_blanked(input logic [4*N_DIGITS-1:0] v,
                                          input logic [N_DIGITS-1:0]   mask,
                                          input logic [1:0]            idx,
                                          input logic                  lzb);
      logic lead_zero;
      lead_zero = 1'b1;
      for (int j = 0; j < N_DIGITS; j++) begin
         if (j >= int'(idx) && v[j*4 +: 4] != 4'h0) lead_zero = 1'b0;
      end
      return mask[idx] | (lzb & (idx != 2'd0) & lead_zero);
   endfunction

   function automatic logic [N_DIGITS-1:0] anode_pattern(input logic [1:0] idx,
                                                          input logic       blanked);
      return blanked ? ANODE_OFF : ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/seg_digit_scanner_edge_sync.sv
// Two-flop synchronizer with rising-edge pulse; a level held high across reset
// release must fall and rise again before it produces a pulse.
module edge_sync (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic pulse
);

   logic s1, s2, s3;
   logic live, armed;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour, which is what makes the chain a shift.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         s3    <= 1'b0;
         live  <= 1'b0;
         armed <= 1'b0;
      end else begin
         s1   <= d;
         s2   <= s1;
         s3   <= s2;
         live <= 1'b1;
         // s1 only carries a real sample once live is set; arm on a seen low.
         if (live && !s1) armed <= 1'b1;
      end
   end

   assign pulse = s2 & ~s3 & armed;

endmodule

// File: rtl/seg_digit_scanner.sv
// Time-multiplexes four hex nibbles onto a 4-digit 7-seg display with a per-frame
// snapshot, all-off dead time between digits and optional leading-zero blanking.
module seg_digit_scanner
   import seg_digit_scanner_pkg::*;
#(
   parameter int DEAD_CYCLES = 4,
   parameter int LZB         = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  scan_clk,
   input  logic [4*N_DIGITS-1:0] value,
   input  logic [N_DIGITS-1:0]   blank_mask,
   output logic [N_DIGITS-1:0]   an,
   output logic [3:0]            digit,
   output logic [1:0]            digit_idx,
   output logic                  frame_start
);

   localparam int CNT_W = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] DEAD_INIT = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
   localparam logic LZB_ON = (LZB != 0);

   scan_state_t           state;
   logic [CNT_W-1:0]      dead_cnt;
   logic [4*N_DIGITS-1:0] snap_value;
   logic [N_DIGITS-1:0]   snap_mask;
   logic                  tick;

   logic [1:0]            next_idx;
   logic                  wrap;
   logic [4*N_DIGITS-1:0] next_value;
   logic [N_DIGITS-1:0]   next_mask;
   logic [3:0]            next_digit;
   logic [N_DIGITS-1:0]   next_an;
   logic [N_DIGITS-1:0]   cur_an;

   edge_sync u_scan_sync (
      .clock (clock),
      .reset (reset),
      .d     (scan_clk),
      .pulse (tick)
   );

   // On a wrap the new digit must come from the live inputs, since the
   // snapshot registers are only loaded on that same edge.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned and infers a latch.
   always_comb begin
      next_idx = 2'd0;
      if (state == ST_DRIVE) next_idx = digit_idx + 2'd1;
      wrap       = (next_idx == 2'd0);
      next_value = wrap ? value      : snap_value;
      next_mask  = wrap ? blank_mask : snap_mask;
      next_digit = nibble_of(next_value, next_idx);
      next_an    = anode_pattern(next_idx, digit_blanked(next_value, next_mask, next_idx, LZB_ON));
      cur_an     = anode_pattern(digit_idx, digit_blanked(snap_value, snap_mask, digit_idx, LZB_ON));
   end

   // NOTE: the snapshot is a handful of flops, not a memory, so it is cleared
   // with the rest of the state to keep outputs deterministic after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_WAIT;
         dead_cnt    <= DEAD_INIT;
         snap_value  <= '0;
         snap_mask   <= '0;
         an          <= ANODE_OFF;
         digit       <= 4'h0;
         digit_idx   <= 2'd0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         case (state)
            ST_WAIT, ST_DRIVE: begin
               if (tick) begin
                  digit_idx <= next_idx;
                  digit     <= next_digit;
                  if (wrap) begin
                     snap_value  <= value;
                     snap_mask   <= blank_mask;
                     frame_start <= 1'b1;
                  end
                  if (DEAD_CYCLES == 0) begin
                     an    <= next_an;
                     state <= ST_DRIVE;
                  end else begin
                     an       <= ANODE_OFF;
                     dead_cnt <= DEAD_INIT;
                     state    <= ST_DEAD;
                  end
               end
            end
            ST_DEAD: begin
               // Ticks landing here are dropped on purpose.
               if (dead_cnt == '0) begin
                  an    <= cur_an;
                  state <= ST_DRIVE;
               end else begin
                  dead_cnt <= dead_cnt - 1'b1;
               end
            end
            default: begin
               an    <= ANODE_OFF;
               state <= ST_WAIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Directed bench for seg_digit_scanner: three instances (dead time, dead time with
// leading-zero blanking, no dead time) share stimulus and a scoreboard queue.
module tb_seg_digit_scanner;

   logic        clock = 1'b0;
   logic        reset;
   logic        scan_clk;
   logic [15:0] value;
   logic [3:0]  blank_mask;

   logic [3:0] an_a, digit_a; logic [1:0] idx_a; logic fs_a;
   logic [3:0] an_z, digit_z; logic [1:0] idx_z; logic fs_z;
   logic [3:0] an_0, digit_0; logic [1:0] idx_0; logic fs_0;

   seg_digit_scanner #(.DEAD_CYCLES(4), .LZB(0)) dut (
      .clock(clock), .reset(reset), .scan_clk(scan_clk), .value(value),
      .blank_mask(blank_mask), .an(an_a), .digit(digit_a), .digit_idx(idx_a),
      .frame_start(fs_a));

   seg_digit_scanner #(.DEAD_CYCLES(4), .LZB(1)) dut_lzb (
      .clock(clock), .reset(reset), .scan_clk(scan_clk), .value(value),
      .blank_mask(blank_mask), .an(an_z), .digit(digit_z), .digit_idx(idx_z),
      .frame_start(fs_z));

   seg_digit_scanner #(.DEAD_CYCLES(0), .LZB(0)) dut_nodead (
      .clock(clock), .reset(reset), .scan_clk(scan_clk), .value(value),
      .blank_mask(blank_mask), .an(an_0), .digit(digit_0), .digit_idx(idx_0),
      .frame_start(fs_0));

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0] idx;
      logic [3:0] digit;
      logic       fs;
      logic [3:0] an_plain;
      logic [3:0] an_lzb;
   } exp_t;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   bit          m_idle   = 1'b1;
   logic [1:0]  m_idx    = 2'd0;
   logic [15:0] m_val    = 16'h0;
   logic [3:0]  m_mask   = 4'h0;
   logic [3:0]  m_an_nd  = 4'hF;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_an(input logic [15:0] v, input logic [3:0] m,
                                         input logic [1:0] i, input bit lzb);
      logic [15:0] upper;
      upper = v >> (4 * int'(i));
      if (m[i] || (lzb && i != 2'd0 && upper == 16'h0)) return 4'hF;
      return ~(4'b0001 << i);
   endfunction

   // One full scan_clk period (32 clocks) starting with a rising edge.
   task automatic tick_step(input string name);
      exp_t       e;
      exp_t       got;
      logic [1:0] prev_idx;
      prev_idx = m_idx;
      if (m_idle || m_idx == 2'd3) begin
         m_idx  = 2'd0;
         m_val  = value;
         m_mask = blank_mask;
         m_idle = 1'b0;
         e.fs   = 1'b1;
      end else begin
         m_idx = m_idx + 2'd1;
         e.fs  = 1'b0;
      end
      e.idx      = m_idx;
      e.digit    = 4'((m_val >> (4 * int'(m_idx))) & 16'hF);
      e.an_plain = exp_an(m_val, m_mask, m_idx, 1'b0);
      e.an_lzb   = exp_an(m_val, m_mask, m_idx, 1'b1);
      exp_q.push_back(e);

      scan_clk = 1'b1;
      repeat (2) @(negedge clock);
      check({name, ":idx_before_edge3"}, 16'(idx_a), 16'(prev_idx));
      check({name, ":nodead_an_before_edge3"}, 16'(an_0), 16'(m_an_nd));
      @(negedge clock);
      got = exp_q.pop_front();
      check({name, ":frame_start"}, 16'(fs_a), 16'(got.fs));
      check({name, ":digit_idx"}, 16'(idx_a), 16'(got.idx));
      check({name, ":digit"}, 16'(digit_a), 16'(got.digit));
      check({name, ":lzb_digit"}, 16'(digit_z), 16'(got.digit));
      check({name, ":an_off_at_advance"}, 16'(an_a), 16'hF);
      check({name, ":nodead_an"}, 16'(an_0), 16'(got.an_plain));
      check({name, ":nodead_idx"}, 16'(idx_0), 16'(got.idx));
      m_an_nd = got.an_plain;
      @(negedge clock);
      check({name, ":frame_start_one_cycle"}, 16'(fs_a), 16'h0);
      repeat (2) @(negedge clock);
      check({name, ":an_dead_last"}, 16'(an_a), 16'hF);
      @(negedge clock);
      check({name, ":an_lit"}, 16'(an_a), 16'(got.an_plain));
      check({name, ":lzb_an_lit"}, 16'(an_z), 16'(got.an_lzb));
      repeat (9) @(negedge clock);
      scan_clk = 1'b0;
      repeat (16) @(negedge clock);
   endtask

   initial begin
      reset      = 1'b1;
      scan_clk   = 1'b0;
      value      = 16'h1234;
      blank_mask = 4'h0;

      // Reset held three cycles while scan_clk toggles.
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("reset_an", 16'(an_a), 16'hF);
         check("reset_digit", 16'(digit_a), 16'h0);
         check("reset_idx", 16'(idx_a), 16'h0);
         check("reset_fs", 16'(fs_a), 16'h0);
         scan_clk = ~scan_clk;
      end
      reset    = 1'b0;
      scan_clk = 1'b0;
      repeat (4) @(negedge clock);
      check("wait_an", 16'(an_a), 16'hF);
      check("wait_idx", 16'(idx_a), 16'h0);
      check("wait_fs", 16'(fs_a), 16'h0);
      repeat (12) @(negedge clock);

      // Full frame of 1234, then wrap.
      tick_step("f1_d0");
      tick_step("f1_d1");
      tick_step("f1_d2");
      tick_step("f1_d3");
      tick_step("f2_d0");
      tick_step("f2_d1");
      tick_step("f2_d2");

      // Mid-frame value change only shows from the next frame.
      value = 16'hABCD;
      tick_step("f2_d3_old");
      tick_step("f3_d0_new");

      value = 16'h0050;
      tick_step("f3_d1");
      tick_step("f3_d2");
      tick_step("f3_d3");
      tick_step("lz50_d0");
      tick_step("lz50_d1");
      tick_step("lz50_d2");
      tick_step("lz50_d3");

      value = 16'h0000;
      tick_step("zero_d0");
      tick_step("zero_d1");
      tick_step("zero_d2");
      tick_step("zero_d3");

      value      = 16'h1234;
      blank_mask = 4'b0101;
      tick_step("mask_d0");
      tick_step("mask_d1");
      tick_step("mask_d2");
      tick_step("mask_d3");

      blank_mask = 4'h0;
      tick_step("pre_rst_d0");
      tick_step("pre_rst_d1");
      tick_step("pre_rst_d2");

      // Reset in DRIVE at idx 2 with scan_clk held high through release.
      scan_clk = 1'b1;
      reset    = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("midrst_an", 16'(an_a), 16'hF);
      check("midrst_idx", 16'(idx_a), 16'h0);
      check("midrst_nodead_an", 16'(an_0), 16'hF);
      check("midrst_fs", 16'(fs_a), 16'h0);
      m_idle  = 1'b1;
      m_idx   = 2'd0;
      m_an_nd = 4'hF;
      repeat (20) @(negedge clock);
      check("held_high_no_adv_idx", 16'(idx_a), 16'h0);
      check("held_high_no_adv_fs_seen", 16'(an_0), 16'hF);
      scan_clk = 1'b0;
      repeat (16) @(negedge clock);
      tick_step("post_rst_d0");
      tick_step("post_rst_d1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
